// File: rtl/dm_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_loader_pkg
//  Description : Shared encodings for the data-memory byte-stream loader:
//                data-memory read/write codes, loader states and a helper
//                that picks the store width from the bytes held in a word.
//  Revision    : 1.0  initial release
// ============================================================================
package dm_loader_pkg;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 11;

    // Data-memory store codes
    localparam logic [1:0] c_DMWR_NOP = 2'b00;
    localparam logic [1:0] c_DMWR_SB  = 2'b01;
    localparam logic [1:0] c_DMWR_SH  = 2'b10;
    localparam logic [1:0] c_DMWR_SW  = 2'b11;

    // Data-memory load code for "no access"
    localparam logic [2:0] c_DMRE_NOP = 3'b000;

    // Loader states
    typedef enum logic [2:0] {
        LD_IDLE       = 3'd0,
        LD_COLLECT    = 3'd1,
        LD_WRITE      = 3'd2,
        LD_WRITE_TAIL = 3'd3,
        LD_DONE       = 3'd4
    } ld_state_t;

    // Store width for a word holding n bytes; a 3-byte word is written as a
    // halfword here and its third byte follows as a separate byte store.
    function automatic logic [1:0] ld_wr_code(input logic [2:0] n);
        logic [1:0] code;
        code = c_DMWR_NOP;
        case (n)
            3'd4:       code = c_DMWR_SW;
            3'd2, 3'd3: code = c_DMWR_SH;
            3'd1:       code = c_DMWR_SB;
            default:    code = c_DMWR_NOP;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_loader_word_pack.sv
`default_nettype none
// ============================================================================
//  Module      : ld_word_pack
//  Description : Little-endian byte-to-word packer. Each pushed byte lands in
//                the next free lane (first byte in [7:0]); the lane count is
//                held alongside and both clear when the word is written.
//  Revision    : 1.0  initial release
// ============================================================================
module ld_word_pack
    import dm_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic [2:0]  o_count
);

    logic [31:0] r_word;
    logic [2:0]  r_count;

    // Lane assembly: clear wins, otherwise drop the byte into lane r_count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_push) begin
            case (r_count[1:0])
                2'd0:    r_word[7:0]   <= i_byte;
                2'd1:    r_word[15:8]  <= i_byte;
                2'd2:    r_word[23:16] <= i_byte;
                default: r_word[31:24] <= i_byte;
            endcase
            r_count <= r_count + 3'd1;
        end
    end

    assign o_word  = r_word;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dm_loader.sv
`default_nettype none
// ============================================================================
//  Module      : dm_loader
//  Description : Byte-stream image loader in front of the data memory. Idle:
//                MEM-stage port passes straight through. On start it stalls
//                the pipeline, packs a little-endian byte stream into words
//                and stores them at consecutive addresses from BASE.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_loader
    import dm_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [1:0]        i_cpu_wr,
    input  logic [2:0]        i_cpu_re,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    output logic              o_cpu_stall,
    output logic [1:0]        o_dm_wr,
    output logic [2:0]        o_dm_re,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [31:0]       o_dm_wdata,
    output logic              o_busy,
    output logic              o_done
);

    // Longest load that fits between BASE and the top of the 1 KiB space,
    // so address arithmetic never wraps.
    localparam logic [LEN_W-1:0] c_MAX_LEN = 11'd1024 - {1'b0, BASE};

    ld_state_t         r_state;
    ld_state_t         w_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_k;
    logic [ADDR_W-1:0] r_addr;

    logic [LEN_W-1:0]  w_len_eff;
    logic              w_accept;
    logic              w_clear;
    logic [31:0]       w_word;
    logic [2:0]        w_count;

    assign w_len_eff = (i_len > c_MAX_LEN) ? c_MAX_LEN : i_len;
    assign w_accept  = o_in_ready & i_in_valid;

    ld_word_pack u_pack (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_accept),
        .i_byte  (i_in_data),
        .i_clear (w_clear),
        .o_word  (w_word),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Load length, running byte count and word address
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_len  <= '0;
            r_k    <= '0;
            r_addr <= '0;
        end else begin
            if (r_state == LD_IDLE && i_start) begin
                r_len  <= w_len_eff;
                r_k    <= '0;
                r_addr <= BASE;
            end else begin
                if (w_accept) begin
                    r_k <= r_k + 11'd1;
                end
                if (r_state == LD_WRITE && w_next == LD_COLLECT) begin
                    r_addr <= r_addr + 10'd4;
                end
            end
        end
    end

    // Next-state decode and data-memory port mux
    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        o_in_ready  = 1'b0;
        o_cpu_stall = 1'b1;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_dm_wr     = c_DMWR_NOP;
        o_dm_re     = c_DMRE_NOP;
        o_dm_addr   = r_addr;
        o_dm_wdata  = '0;

        case (r_state)
            LD_IDLE: begin
                o_cpu_stall = 1'b0;
                o_busy      = 1'b0;
                o_dm_wr     = i_cpu_wr;
                o_dm_re     = i_cpu_re;
                o_dm_addr   = i_cpu_addr;
                o_dm_wdata  = i_cpu_wdata;
                if (i_start) begin
                    w_next = (w_len_eff == '0) ? LD_DONE : LD_COLLECT;
                end
            end
            LD_COLLECT: begin
                o_in_ready = 1'b1;
                if (w_accept && (w_count == 3'd3 || (r_k + 11'd1) == r_len)) begin
                    w_next = LD_WRITE;
                end
            end
            LD_WRITE: begin
                o_dm_wr = ld_wr_code(w_count);
                if (w_count == 3'd3) begin
                    // Low halfword now; lane 2 is kept for the tail store
                    o_dm_wdata = {16'h0000, w_word[15:0]};
                    w_next     = LD_WRITE_TAIL;
                end else begin
                    o_dm_wdata = w_word;
                    w_clear    = 1'b1;
                    w_next     = (r_k < r_len) ? LD_COLLECT : LD_DONE;
                end
            end
            LD_WRITE_TAIL: begin
                o_dm_wr    = c_DMWR_SB;
                o_dm_addr  = r_addr + 10'd2;
                o_dm_wdata = {24'h000000, w_word[23:16]};
                w_clear    = 1'b1;
                w_next     = LD_DONE;
            end
            LD_DONE: begin
                o_done = 1'b1;
                w_next = LD_IDLE;
            end
            default: begin
                w_next = LD_IDLE;
            end
        endcase

        // Quiet port while reset is held
        if (!rstn) begin
            w_clear     = 1'b0;
            o_in_ready  = 1'b0;
            o_cpu_stall = 1'b0;
            o_busy      = 1'b0;
            o_done      = 1'b0;
            o_dm_wr     = c_DMWR_NOP;
            o_dm_re     = c_DMRE_NOP;
            o_dm_addr   = '0;
            o_dm_wdata  = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_loader
//  Description : Self-checking bench for dm_loader: reset, idle pass-through,
//                table-driven and random loads compared against a word-level
//                reference model, start-while-busy and reset-mid-load cases.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dm_loader;
    import dm_loader_pkg::*;

    localparam int c_BASE = 0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_start = 1'b0;
    logic [10:0] i_len = '0;
    logic [7:0]  i_in_data = '0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [1:0]  i_cpu_wr = '0;
    logic [2:0]  i_cpu_re = '0;
    logic [9:0]  i_cpu_addr = '0;
    logic [31:0] i_cpu_wdata = '0;
    logic        o_cpu_stall;
    logic [1:0]  o_dm_wr;
    logic [2:0]  o_dm_re;
    logic [9:0]  o_dm_addr;
    logic [31:0] o_dm_wdata;
    logic        o_busy;
    logic        o_done;

    always #5 clk = ~clk;

    dm_loader #(.BASE(10'(c_BASE))) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_in_data   (i_in_data),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_cpu_wr    (i_cpu_wr),
        .i_cpu_re    (i_cpu_re),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wdata (i_cpu_wdata),
        .o_cpu_stall (o_cpu_stall),
        .o_dm_wr     (o_dm_wr),
        .o_dm_re     (o_dm_re),
        .o_dm_addr   (o_dm_addr),
        .o_dm_wdata  (o_dm_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Observed stores {wr, addr, wdata}, done pulses and busy-time port faults
    logic [43:0] wq[$];
    logic [43:0] exp_q[$];
    int          done_cnt = 0;
    int          bad_busy = 0;
    logic [7:0]  bytes[2048];

    always @(negedge clk) begin
        if (rstn) begin
            if (o_busy && o_dm_wr != c_DMWR_NOP) wq.push_back({o_dm_wr, o_dm_addr, o_dm_wdata});
            if (o_done) done_cnt++;
            if (o_busy && (!o_cpu_stall || o_dm_re != c_DMRE_NOP || o_in_ready && o_dm_wr != c_DMWR_NOP))
                bad_busy++;
        end
    end

    // Reference: split L bytes into 4-byte words and list the stores they need
    task automatic build_expected(input int L);
        exp_q.delete();
        for (int w = 0; w * 4 < L; w++) begin
            int          n;
            logic [31:0] v;
            logic [9:0]  a;
            n = (L - w * 4 >= 4) ? 4 : L - w * 4;
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(bytes[w * 4 + i]) << (8 * i));
            a = 10'(c_BASE + 4 * w);
            case (n)
                4: exp_q.push_back({c_DMWR_SW, a, v});
                2: exp_q.push_back({c_DMWR_SH, a, v});
                1: exp_q.push_back({c_DMWR_SB, a, v});
                default: begin
                    exp_q.push_back({c_DMWR_SH, a, v & 32'h0000FFFF});
                    exp_q.push_back({c_DMWR_SB, 10'(a + 2), 32'(bytes[w * 4 + 2])});
                end
            endcase
        end
    endtask

    task automatic run_load(input string tag, input int len, input int gap_at, input int gap_n,
                            input bit rnd_gaps, input bit poke_start);
        int L, j, cyc, gap_left, idle_gaps, exp_cyc;
        bit acc;
        L = (len > 1024 - c_BASE) ? 1024 - c_BASE : len;
        j = 0; cyc = 0; gap_left = 0; idle_gaps = 0;
        build_expected(L);
        @(negedge clk);
        wq.delete(); done_cnt = 0; bad_busy = 0;
        i_start = 1'b1; i_len = 11'(len);
        i_cpu_wr = c_DMWR_SH; i_cpu_re = 3'd0; i_cpu_addr = 10'h155; i_cpu_wdata = 32'hCAFE0001;
        #1 check({tag, "_startpass"}, {o_dm_wr, o_dm_addr, o_dm_wdata, o_cpu_stall},
                 {c_DMWR_SH, 10'h155, 32'hCAFE0001, 1'b0});
        @(posedge clk); #1;
        i_start = 1'b0;
        i_cpu_wr = c_DMWR_SW; i_cpu_re = 3'd5; i_cpu_addr = 10'h2A8; i_cpu_wdata = 32'hDEADBEEF;
        while (o_busy && cyc < 4000) begin
            if (poke_start && cyc == 2) begin i_start = 1'b1; i_len = 11'd3; end
            else i_start = 1'b0;
            if (o_in_ready && j < L) begin
                if (gap_left > 0) begin
                    i_in_valid = 1'b0; gap_left--; idle_gaps++;
                end else if (rnd_gaps && $urandom_range(0, 3) == 0) begin
                    i_in_valid = 1'b0; idle_gaps++;
                end else begin
                    i_in_valid = 1'b1; i_in_data = bytes[j];
                end
            end else begin
                i_in_valid = 1'b0;
            end
            acc = i_in_valid && o_in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                j++;
                if (j == gap_at) gap_left = gap_n;
            end
        end
        i_in_valid = 1'b0; i_start = 1'b0; i_cpu_wr = c_DMWR_NOP; i_cpu_re = 3'd0;
        exp_cyc = L + (L + 3) / 4 + 1 + ((L % 4) == 3 ? 1 : 0) + idle_gaps;
        check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_bytes"}, 64'(j), 64'(L));
        check({tag, "_done"}, 64'(done_cnt), 64'd1);
        check({tag, "_portguard"}, 64'(bad_busy), 64'd0);
        check({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(wq[i]), 64'(exp_q[i]));
    endtask

    typedef struct {
        int len;
        int gap_at;
        int gap_n;
        bit poke;
        int pattern;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4,    -1, 0, 1'b0, 0};
        vecs[1] = '{7,    -1, 0, 1'b0, 1};
        vecs[2] = '{5,     2, 3, 1'b0, 1};
        vecs[3] = '{0,    -1, 0, 1'b0, 2};
        vecs[4] = '{1,    -1, 0, 1'b0, 2};
        vecs[5] = '{2,    -1, 0, 1'b0, 2};
        vecs[6] = '{3,    -1, 0, 1'b0, 2};
        vecs[7] = '{9,    -1, 0, 1'b1, 2};
        vecs[8] = '{1030, -1, 0, 1'b0, 2};

        // Reset held two cycles with a CPU store pending
        rstn = 1'b0; i_cpu_wr = c_DMWR_SW; i_cpu_re = 3'd1;
        i_cpu_addr = 10'h123; i_cpu_wdata = 32'h12345678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dm", {o_dm_wr, o_dm_re, o_dm_addr, o_dm_wdata}, '0);
        check("rst_ctl", {o_cpu_stall, o_busy, o_done, o_in_ready}, 4'b0000);
        rstn = 1'b1;
        @(negedge clk);

        // Idle pass-through
        i_cpu_wr = c_DMWR_SW; i_cpu_re = 3'd2; i_cpu_addr = 10'h3F0; i_cpu_wdata = 32'hA5A5_0F0F;
        #1 check("idle_pass", {o_dm_wr, o_dm_re, o_dm_addr, o_dm_wdata},
                 {c_DMWR_SW, 3'd2, 10'h3F0, 32'hA5A5_0F0F});
        check("idle_ctl", {o_cpu_stall, o_busy, o_in_ready}, 3'b000);
        i_cpu_wr = c_DMWR_NOP; i_cpu_re = 3'd0;

        // Reset after 2 of 4 bytes: nothing stored, no done
        @(negedge clk);
        wq.delete(); done_cnt = 0;
        i_start = 1'b1; i_len = 11'd4;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_in_valid = 1'b1; i_in_data = 8'hAA;
        @(posedge clk); #1;
        i_in_data = 8'hBB;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_busy", {o_busy, o_cpu_stall}, 2'b00);
        check("midrst_writes", 64'(wq.size()), 64'd0);
        check("midrst_done", 64'(done_cnt), 64'd0);

        // Table-driven loads
        for (int v = 0; v < 9; v++) begin
            for (int j = 0; j < 2048; j++) begin
                case (vecs[v].pattern)
                    0:       bytes[j] = 8'((j + 1) * 17);
                    1:       bytes[j] = 8'(j + 1);
                    default: bytes[j] = 8'($urandom);
                endcase
            end
            run_load($sformatf("vec%0d", v), vecs[v].len, vecs[v].gap_at, vecs[v].gap_n,
                     1'b0, vecs[v].poke);
            if (v == 0 && wq.size() > 0)
                check("len4_word", 64'(wq[0]), 64'({c_DMWR_SW, 10'h000, 32'h44332211}));
            if (v == 1 && wq.size() == 3)
                check("len7_tail", 64'(wq[2]), 64'({c_DMWR_SB, 10'h006, 32'h00000007}));
        end

        // Random loads with random stream gaps
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 64; j++) bytes[j] = 8'($urandom);
            run_load($sformatf("rnd%0d", r), int'($urandom_range(0, 40)), -1, 0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
